rf_ctrl: RTL and testbench

RF_CTRL -- requirements
Module: rf_ctrl

---
 rtl/rf_ctrl.sv | 146 ++++++++++++++
 tb/tb_rf_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rf_ctrl.sv
// rf_ctrl: single-outstanding request/response front end for a register file
// with a registered read port.
//
// Optional build macro RF_CTRL_ADDR_CHK_EN: when defined, requests whose
// address is at or above MEM_DPTH are answered with rsp_err=1 and never reach
// the register file. Without it every address is forwarded and rsp_err stays 0.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for a request (req_ready=1)
// WRITE | one-cycle write strobe to the register file
// READ  | one-cycle read strobe; register file registers data at the next edge
// CAPT  | register-file read data is loaded into rsp_rdata
// RESP  | response presented, held until rsp_ready
module rf_ctrl #(
  parameter int ADDR_WDTH = 3,
  parameter int DATA_WDTH = 16,
  parameter int MEM_DPTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_WDTH-1:0] req_addr,
  input  logic [DATA_WDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_WDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 rf_WrEn,
  output logic                 rf_RdEn,
  output logic [ADDR_WDTH-1:0] rf_Address,
  output logic [DATA_WDTH-1:0] rf_WrData,
  input  logic [DATA_WDTH-1:0] rf_RdData,
  output logic [7:0]           txn_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    CAPT  = 3'd3,
    RESP  = 3'd4
  } state_t;

`ifdef RF_CTRL_ADDR_CHK_EN
  localparam logic LP_CHK_EN = 1'b1;
`else
  localparam logic LP_CHK_EN = 1'b0;
`endif

  // One extra bit so MEM_DPTH == 2**ADDR_WDTH is representable.
  localparam int                 LP_DPTH_INT = MEM_DPTH;
  localparam logic [ADDR_WDTH:0] LP_DPTH     = LP_DPTH_INT[ADDR_WDTH:0];

  state_t                 r_state;
  state_t                 w_nxt_state;
  logic [ADDR_WDTH-1:0]   r_addr;
  logic [DATA_WDTH-1:0]   r_wdata;
  logic [DATA_WDTH-1:0]   r_rdata;
  logic                   r_err;
  logic [7:0]             r_cnt;
  logic                   w_accept;
  logic                   w_addr_bad;
  logic                   w_rsp_done;
  logic                   w_wr_en;
  logic                   w_rd_en;
  logic                   w_rsp_valid;

  // Ready is gated by RST so nothing is offered while reset is held.
  assign req_ready  = (r_state == IDLE) & RST;
  assign w_accept   = req_valid & req_ready;
  assign w_addr_bad = LP_CHK_EN & ({1'b0, req_addr} >= LP_DPTH);
  assign w_rsp_done = (r_state == RESP) & rsp_ready;

  assign rsp_valid  = w_rsp_valid;
  assign rsp_rdata  = r_rdata;
  assign rsp_err    = r_err;
  assign rf_WrEn    = w_wr_en;
  assign rf_RdEn    = w_rd_en;
  assign rf_Address = r_addr;
  assign rf_WrData  = r_wdata;
  assign txn_cnt    = r_cnt;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_nxt_state;
  end

  // Next-state and strobe decode; strobes are pure state decodes so they
  // drop the instant reset forces IDLE.
  always_comb begin
    w_nxt_state = r_state;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_addr_bad)  w_nxt_state = RESP;
          else if (req_wr) w_nxt_state = WRITE;
          else             w_nxt_state = READ;
        end
      end
      WRITE: begin
        w_wr_en     = 1'b1;
        w_nxt_state = RESP;
      end
      READ: begin
        w_rd_en     = 1'b1;
        w_nxt_state = CAPT;
      end
      CAPT: begin
        w_nxt_state = RESP;
      end
      RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) w_nxt_state = IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // Request capture, response data/error and completed-transaction counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rdata <= '0;
        r_err   <= w_addr_bad;
      end
      if (r_state == CAPT) r_rdata <= rf_RdData;
      if (w_rsp_done)      r_cnt   <= r_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rf_ctrl.sv
// Randomized bench for rf_ctrl with a behavioural register-file reference.
module tb_rf_ctrl;
  localparam int AW    = 3;
  localparam int DW    = 16;
  localparam int DEPTH = 6;

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          rf_WrEn, rf_RdEn;
  logic [AW-1:0] rf_Address;
  logic [DW-1:0] rf_WrData;
  logic [DW-1:0] rf_RdData = '0;
  logic [7:0]    txn_cnt;

  rf_ctrl #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .MEM_DPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rf_WrEn(rf_WrEn), .rf_RdEn(rf_RdEn), .rf_Address(rf_Address),
    .rf_WrData(rf_WrData), .rf_RdData(rf_RdData), .txn_cnt(txn_cnt)
  );

  always #5 CLK = ~CLK;

  // Register file attached to the controller (8 physical entries).
  logic [DW-1:0] rf_mem [8] = '{default: '0};
  always @(posedge CLK) begin
    if (rf_WrEn) rf_mem[rf_Address] <= rf_WrData;
    if (rf_RdEn) rf_RdData <= rf_mem[rf_Address];
  end

  int both_seen = 0;
  always @(negedge CLK) if (rf_WrEn && rf_RdEn) both_seen++;

  // Reference model state.
  logic [DW-1:0] exp_mem [8];
  int            exp_cnt;
  int            n_chk  = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit addr_err(input int a);
`ifdef RF_CTRL_ADDR_CHK_EN
    return a >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge with the controller idle; returns at a negedge.
  task automatic do_txn(input bit wr, input int addr, input logic [DW-1:0] wd,
                        input int stall, input bit junk);
    bit            err;
    int            lat, nwr, nrd, exp_lat;
    logic [DW-1:0] exp_rd;
    err     = addr_err(addr);
    exp_rd  = (wr || err) ? '0 : exp_mem[addr];
    exp_lat = err ? 0 : (wr ? 1 : 2);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_wr = wr; req_addr = AW'(addr); req_wdata = wd;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0; req_wr = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
    lat = 0; nwr = 0; nrd = 0;
    while (!rsp_valid && lat < 10) begin
      if (rf_WrEn) begin
        nwr++;
        chk("wr_addr", rf_Address, addr);
        chk("wr_data", rf_WrData, wd);
      end
      if (rf_RdEn) begin
        nrd++;
        chk("rd_addr", rf_Address, addr);
      end
      @(negedge CLK);
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("wr_strobes", nwr, (wr && !err) ? 1 : 0);
    chk("rd_strobes", nrd, (!wr && !err) ? 1 : 0);
    chk("strobe_in_resp", {rf_WrEn, rf_RdEn}, 0);
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", rsp_err, err);
    chk("req_ready_busy", req_ready, 0);
    if (wr && !err) exp_mem[addr] = wd;
    for (int i = 0; i < stall; i++) begin
      rsp_ready = 1'b0;
      if (junk) begin
        req_valid = 1'b1; req_wr = 1'($urandom);
        req_addr = AW'($urandom); req_wdata = DW'($urandom);
      end
      @(negedge CLK);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, exp_rd);
      chk("stall_err", rsp_err, err);
      chk("stall_ready", req_ready, 0);
      chk("stall_strobes", {rf_WrEn, rf_RdEn}, 0);
      chk("stall_cnt", txn_cnt, exp_cnt);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge CLK);
    rsp_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    chk("rsp_dropped", rsp_valid, 0);
    chk("txn_cnt", txn_cnt, exp_cnt);
    chk("req_ready_after", req_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
    exp_cnt = 0;
    RST = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_txn_cnt", txn_cnt, 0);
    chk("rst_strobes", {rf_WrEn, rf_RdEn}, 0);
    chk("rst_rf_addr", rf_Address, 0);
    chk("rst_rf_wdata", rf_WrData, 0);
    RST = 1'b1;
    @(negedge CLK);

    // Directed write then read-back.
    do_txn(1'b1, 3, 16'hA5A5, 0, 1'b0);
    chk("first_cnt", txn_cnt, 1);
    do_txn(1'b0, 3, '0, 0, 1'b0);
    // Long consumer stall with competing requests.
    do_txn(1'b1, 1, 16'h1234, 5, 1'b1);
    do_txn(1'b0, 1, '0, 5, 1'b1);
    // Addresses beyond the implemented depth.
    do_txn(1'b0, 7, '0, 1, 1'b0);
    do_txn(1'b1, 6, 16'hBEEF, 0, 1'b0);
    do_txn(1'b0, 6, '0, 0, 1'b0);

    for (int n = 0; n < 80; n++)
      do_txn(1'($urandom), int'($urandom_range(0, 7)), DW'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom));

    // Reset asserted while in READ.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 3'd2;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("pre_rst_rden", rf_RdEn, 1);
    RST = 1'b0;
    #1;
    exp_cnt = 0;
    chk("midrst_rden", rf_RdEn, 0);
    chk("midrst_wren", rf_WrEn, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_txn_cnt", txn_cnt, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_rf_addr", rf_Address, 0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("postrst_no_rsp", rsp_valid, 0);
      chk("postrst_idle", req_ready, 1);
    end
    do_txn(1'b0, 2, '0, 0, 1'b0);

    // 256 more writes wrap the counter back to its starting value.
    for (int n = 0; n < 256; n++) begin
      do_txn(1'b1, n % DEPTH, DW'($urandom), 0, 1'b0);
      if (n == 253) chk("cnt_255", txn_cnt, 255);
    end
    chk("cnt_wrap", txn_cnt, 1);
    do_txn(1'b0, 4, '0, 0, 1'b0);
    chk("never_both_strobes", both_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
